// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order requests to
// instruction memory, queues returned words and presents {inst, pc, pc+4} to decode.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [31:0]     inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] target_pc;
  logic            issue;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            unused_pc_bits;

  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign imem_req    = rst & (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign issue = imem_req & imem_gnt;
  assign rsp   = imem_rvalid & (inflight != '0);
  assign push  = rsp & ~redirect & (drop_cnt == '0);
  assign pop   = id_valid & id_ready;

  assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    inflight_nxt = inflight;
    if (issue && !rsp)
      inflight_nxt = inflight + CW'(1);
    else if (rsp && !issue)
      inflight_nxt = inflight - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        // Every response outstanding after this cycle is stale; any earlier drops are a subset.
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop_cnt <= inflight_nxt;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && drop_cnt != '0)
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= resp_pc;
    end
  end

  assign id_valid    = (count != '0);
  assign id_inst     = id_valid ? inst_q[rd_ptr] : NOP;
  assign id_pc       = id_valid ? pc_q[rd_ptr] : resp_pc;
  assign id_pc_plus4 = id_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory responder plus hand-computed
// expectations for startup, stall, redirect, alignment, PC wrap and mid-run reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_issue  = 0;
  int unsigned issue_base;
  logic        rsp_en;
  logic [31:0] pend [$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Memory: accepts on req&gnt, answers in order one cycle later while rsp_en is set.
  always @(posedge clk) begin
    if (imem_rvalid && pend.size() != 0) void'(pend.pop_front());
    if (imem_req && imem_gnt) begin
      pend.push_back(imem_addr);
      n_issue++;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rsp_en && pend.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!id_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(id_valid), 32'd1);
  endtask

  task automatic do_reset();
    imem_gnt = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    rsp_en   = 1'b1;
    for (int i = 0; i < 20 && pend.size() != 0; i++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    issue_base = n_issue;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    id_ready = 1'b0; rsp_en = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_inst", id_inst, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h4);
    rst = 1'b1;
    #1;
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, 32'h0);

    // 1: single-cycle memory, one instruction per cycle after startup
    imem_gnt = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    check("t1_latency", 32'(id_valid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("t1_valid", 32'(id_valid), 32'd1);
      check("t1_pc", id_pc, 32'(4 * k));
      check("t1_pc4", id_pc_plus4, 32'(4 * k + 4));
      check("t1_inst", id_inst, inst_of(32'(4 * k)));
      @(negedge clk);
    end

    // 2: stall until credit runs out, then drain in order
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_issues", 32'(n_issue - issue_base), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_pc", id_pc, 32'h0);
      check("t2_hold_inst", id_inst, inst_of(32'h0));
      check("t2_hold_valid", 32'(id_valid), 32'd1);
      @(negedge clk);
    end
    check("t2_issues_held", 32'(n_issue - issue_base), 32'd4);
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("t2_drain_valid", 32'(id_valid), 32'd1);
      check("t2_drain_pc", id_pc, 32'(4 * k));
      @(negedge clk);
    end

    // 3: redirect with requests outstanding; stale words dropped
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3_credit", 32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0; rsp_en = 1'b1;
    check("t3_addr", imem_addr, 32'h0000_0100);
    check("t3_flushed", 32'(id_valid), 32'd0);
    wait_valid("t3");
    check("t3_first_pc", id_pc, 32'h0000_0100);
    check("t3_first_inst", id_inst, inst_of(32'h0000_0100));
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t3_seq_pc", id_pc, 32'(32'h100 + 4 * k));
    end

    // 4: unaligned target, redirect coincident with a response
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    check("t4_empty", 32'(id_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    check("t4_addr", imem_addr, 32'h0000_0200);
    wait_valid("t4");
    check("t4_first_pc", id_pc, 32'h0000_0200);
    check("t4_first_inst", id_inst, inst_of(32'h0000_0200));

    // 5: PC wrap at top of address space
    check("t5_req", 32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t5_req_top", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("t5_addr_wrap", imem_addr, 32'h0);
    wait_valid("t5");
    check("t5_pc_top", id_pc, 32'hFFFF_FFFC);
    check("t5_pc4_wrap", id_pc_plus4, 32'h0);
    @(negedge clk);
    check("t5_pc_zero", id_pc, 32'h0);
    check("t5_pc4_zero", id_pc_plus4, 32'h4);

    // 6: reset with words queued and in flight; late responses ignored
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rsp_en = 1'b0;
    @(negedge clk);
    check("t6_full_req", 32'(imem_req), 32'd0);
    check("t6_full_valid", 32'(id_valid), 32'd1);
    rst = 1'b0; imem_gnt = 1'b0; rsp_en = 1'b1;
    #1;
    check("t6_rst_valid", 32'(id_valid), 32'd0);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_inst", id_inst, NOP);
    check("t6_rst_pc", id_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_late_valid", 32'(id_valid), 32'd0);
    check("t6_late_req", 32'(imem_req), 32'd1);
    check("t6_late_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1; id_ready = 1'b1;
    wait_valid("t6");
    check("t6_restart_pc", id_pc, 32'h0);
    check("t6_restart_inst", id_inst, inst_of(32'h0));
    @(negedge clk);
    check("t6_next_pc", id_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
